// File: rtl/fetch_queue.sv
// fetch_queue: circular-buffer instruction queue between fetch and decode
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     fetch_stall,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] last_ptr = AW'(DEPTH - 1);
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign fetch_stall = count == full_cnt;
  assign out_valid = count != '0;
  assign push = in_valid && !fetch_stall && !flush;
  assign pop = out_valid && out_ready && !flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == last_ptr ? '0 : wp + 1'b1;
      if (pop) rp <= rp == last_ptr ? '0 : rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage is left unreset; the outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp] <= in_pc;
      instr_mem[wp] <= in_instr;
    end
  end
  always_comb begin
    out_pc = out_valid ? pc_mem[rp] : '0;
    out_instr = out_valid ? instr_mem[rp] : '0;
    out_pc_plus4 = out_valid ? pc_mem[rp] + 32'd4 : '0;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic fetch_stall, out_valid;
  logic [31:0] out_pc, out_instr, out_pc_plus4;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, errors = 0;
  logic [63:0] q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_stall(fetch_stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic v;
    v = q.size() != 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".count"}, 32'(count), q.size());
    chk({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(q.size() == DEPTH));
    chk({tag, ".out_pc"}, out_pc, v ? q[0][63:32] : 32'h0);
    chk({tag, ".out_instr"}, out_instr, v ? q[0][31:0] : 32'h0);
    chk({tag, ".out_pc_plus4"}, out_pc_plus4, v ? q[0][63:32] + 32'd4 : 32'h0);
  endtask

  // one clock: drive, let the edge happen, update the model by the queue rules, compare
  task automatic cyc(input string tag, input logic v, input logic [31:0] pc,
                     input logic [31:0] ins, input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
    do_push = v && q.size() < DEPTH && !fl;
    do_pop = rdy && q.size() != 0 && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({pc, ins});
    end
    in_valid = 0; out_ready = 0; flush = 0;
    chk_all(tag);
  endtask

  initial begin
    #1 chk_all("reset");
    in_valid = 1; in_pc = 32'h40;
    @(posedge clk);
    #1 chk_all("reset_hold");
    in_valid = 0;
    reset = 1;
    cyc("single", 1, 32'h0, 32'h0050_0093, 0, 0);
    chk("single.pc_plus4", out_pc_plus4, 32'h4);
    cyc("drain1", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("fill", 1, 32'(i * 4), 32'hA000 + 32'(i), 0, 0);
    chk("fill.stall", 32'(fetch_stall), 32'h1);
    cyc("fifth", 1, 32'h10, 32'hBEEF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("order", out_pc, 32'(i * 4));
      cyc("pop", 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc("stream", 1, 32'(i * 4), 32'h1000 + 32'(i), 1, 0);
      chk("stream.follow", out_pc, 32'(i * 4));
    end
    cyc("stream_end", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("pre_flush", 1, 32'h80 + 32'(i * 4), 32'(i), 0, 0);
    cyc("flush", 1, 32'h100, 32'h1111, 1, 1);
    cyc("post_flush", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("refill", 1, 32'h300 + 32'(i * 4), 32'(i), 0, 0);
    cyc("full_pop", 1, 32'h400, 32'h2222, 1, 0);
    chk("full_pop.count", 32'(count), 32'd3);
    cyc("wrap_pc", 1, 32'hFFFF_FFFC, 32'h3333, 0, 0);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 0, 0, 1, 0);
    chk("wrap_pc.plus4", out_pc_plus4, 32'h0);
    cyc("drain_last", 0, 0, 0, 1, 0);
    cyc("pre_rst", 1, 32'h500, 32'h5, 0, 0);
    cyc("pre_rst", 1, 32'h504, 32'h6, 0, 0);
    #2 reset = 0;
    #1 q.delete();
    chk_all("async_rst");
    #2 reset = 1;
    cyc("post_rst", 1, 32'h200, 32'h7, 0, 0);
    chk("post_rst.pc", out_pc, 32'h200);
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom_range(0, 15) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
